// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC and opcode field.
package instruction_fetch_unit_pkg;

   typedef enum logic [1:0] {
      REQ      = 2'd0,
      WAIT_ACK = 2'd1,
      HOLD     = 2'd2,
      ERROR    = 2'd3
   } fetchState_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
   localparam int          OP_MSB           = 31;
   localparam int          OP_LSB           = 26;

   function automatic logic isWordAligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter register with load enable; resets to the configured fetch start address.
module pc_register
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] nextPc,
   output logic [31:0] pc
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= nextPc;
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch FSM: one outstanding memory request, holds each instruction until accepted.
// Define DELAY_SLOT_EN to fetch the instruction after a taken redirect before its target.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemAck,
   input  logic [31:0] ImemRdata,
   output logic        InstrValid,
   input  logic        InstrReady,
   output logic [31:0] InstrOut,
   output logic [5:0]  OP,
   output logic [31:0] PCOut,
   output logic [31:0] PCPlus4,
   input  logic        Redirect,
   input  logic [31:0] RedirectTarget,
   output logic        FetchError
);

   fetchState_t state;
   logic [31:0] pc;
   logic [31:0] pcNext;
   logic        accept;
   logic        takeRedirect;
   logic        misaligned;
   logic        pcLoad;

   assign accept     = (state == HOLD) && InstrReady;
   assign misaligned = takeRedirect && !isWordAligned(RedirectTarget);
   assign pcLoad     = accept && !misaligned;

`ifdef DELAY_SLOT_EN
   logic        inDelaySlot;
   logic [31:0] slotTarget;

   // The delay-slot instruction cannot redirect; it only releases the pending target.
   assign takeRedirect = Redirect && !inDelaySlot;
   assign pcNext       = inDelaySlot ? slotTarget : pc + 32'd4;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inDelaySlot <= 1'b0;
         slotTarget  <= '0;
      end else if (accept) begin
         if (inDelaySlot) begin
            inDelaySlot <= 1'b0;
         end else if (takeRedirect && isWordAligned(RedirectTarget)) begin
            inDelaySlot <= 1'b1;
            slotTarget  <= RedirectTarget;
         end
      end
   end
`else
   assign takeRedirect = Redirect;
   assign pcNext       = takeRedirect ? RedirectTarget : pc + 32'd4;
`endif

   pc_register #(.RESET_PC(RESET_PC)) uPc (
      .clk    (clk),
      .reset  (reset),
      .load   (pcLoad),
      .nextPc (pcNext),
      .pc     (pc)
   );

   // ImemReq resets low, so the first REQ cycle after reset only raises the request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= REQ;
         ImemReq    <= 1'b0;
         InstrValid <= 1'b0;
         InstrOut   <= '0;
         PCOut      <= '0;
         FetchError <= 1'b0;
      end else begin
         case (state)
            REQ, WAIT_ACK: begin
               if (!ImemReq) begin
                  ImemReq <= 1'b1;
               end else if (ImemAck) begin
                  InstrOut   <= ImemRdata;
                  PCOut      <= pc;
                  InstrValid <= 1'b1;
                  ImemReq    <= 1'b0;
                  state      <= HOLD;
               end else begin
                  state <= WAIT_ACK;
               end
            end
            HOLD: begin
               if (InstrReady) begin
                  InstrValid <= 1'b0;
                  if (misaligned) begin
                     FetchError <= 1'b1;
                     state      <= ERROR;
                  end else begin
                     ImemReq <= 1'b1;
                     state   <= REQ;
                  end
               end
            end
            default: begin
               ImemReq    <= 1'b0;
               InstrValid <= 1'b0;
               FetchError <= 1'b1;
               state      <= ERROR;
            end
         endcase
      end
   end

   assign ImemAddr = pc;
   assign OP       = InstrOut[OP_MSB:OP_LSB];
   assign PCPlus4  = PCOut + 32'd4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed table, corner sequences, random run vs model.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        reset;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemAck;
   logic [31:0] ImemRdata;
   logic        InstrValid;
   logic        InstrReady;
   logic [31:0] InstrOut;
   logic [5:0]  OP;
   logic [31:0] PCOut;
   logic [31:0] PCPlus4;
   logic        Redirect;
   logic [31:0] RedirectTarget;
   logic        FetchError;

   int total = 0;
   int bad   = 0;

`ifdef DELAY_SLOT_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif

   instruction_fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .ImemReq        (ImemReq),
      .ImemAddr       (ImemAddr),
      .ImemAck        (ImemAck),
      .ImemRdata      (ImemRdata),
      .InstrValid     (InstrValid),
      .InstrReady     (InstrReady),
      .InstrOut       (InstrOut),
      .OP             (OP),
      .PCOut          (PCOut),
      .PCPlus4        (PCPlus4),
      .Redirect       (Redirect),
      .RedirectTarget (RedirectTarget),
      .FetchError     (FetchError)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        expReq;
      logic [31:0] expAddr;
      logic        expValid;
      logic [31:0] expPc;
      logic        ack;
      logic        rdy;
      logic        redir;
      logic [31:0] target;
   } row_t;

   row_t tbl[$];

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chkInstr(input string tag, input logic [31:0] pcExp);
      logic [31:0] w;
      logic [31:0] p4;
      w  = memWord(pcExp);
      p4 = pcExp + 32'd4;
      chk({tag, "_pcout"}, PCOut, pcExp);
      chk({tag, "_instr"}, InstrOut, w);
      chk({tag, "_plus4"}, PCPlus4, p4);
      chk({tag, "_op"}, {26'd0, OP}, {26'd0, w[31:26]});
   endtask

   task automatic drive(input logic ack, input logic rdy, input logic rd, input logic [31:0] tgt);
      ImemAck        = ack;
      ImemRdata      = ack ? memWord(ImemAddr) : ~memWord(ImemAddr);
      InstrReady     = rdy;
      Redirect       = rd;
      RedirectTarget = tgt;
   endtask

   task automatic doReset();
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic addRow(input logic eReq, input logic [31:0] eAddr, input logic eVal,
                         input logic [31:0] ePc, input logic ack, input logic rdy,
                         input logic rd, input logic [31:0] tgt);
      row_t r;
      r.expReq = eReq; r.expAddr = eAddr; r.expValid = eVal; r.expPc = ePc;
      r.ack = ack; r.rdy = rdy; r.redir = rd; r.target = tgt;
      tbl.push_back(r);
   endtask

   initial begin
      logic [31:0] afterRedir;
      logic [31:0] thirdAddr;
      logic [31:0] fetchPc;
      logic [31:0] slotTarget;
      logic        inSlot;
      logic        expValid;
      logic        ack, rdy, rd;
      logic [31:0] tgt;
      int          accepts;

      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'd0);

      afterRedir = DS ? 32'h0040_0014 : 32'h0040_0100;
      thirdAddr  = DS ? 32'h0040_0100 : 32'h0040_0200;

      // zero-wait stream, HOLD stall, 3-cycle ack delay, redirect
      addRow(1, 32'h0040_0000, 0, 0,             1, 1, 0, 0);
      addRow(0, 0,             1, 32'h0040_0000, 1, 1, 0, 0);
      addRow(1, 32'h0040_0004, 0, 0,             1, 1, 0, 0);
      addRow(0, 0,             1, 32'h0040_0004, 1, 1, 0, 0);
      addRow(1, 32'h0040_0008, 0, 0,             1, 1, 0, 0);
      for (int i = 0; i < 4; i++)
         addRow(0, 0,          1, 32'h0040_0008, 1, 0, 0, 0);
      addRow(0, 0,             1, 32'h0040_0008, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++)
         addRow(1, 32'h0040_000C, 0, 0,          0, 1, 0, 0);
      addRow(1, 32'h0040_000C, 0, 0,             1, 1, 0, 0);
      addRow(0, 0,             1, 32'h0040_000C, 1, 1, 0, 0);
      addRow(1, 32'h0040_0010, 0, 0,             1, 1, 1, 32'h0040_0003);
      addRow(0, 0,             1, 32'h0040_0010, 1, 1, 1, 32'h0040_0100);
      addRow(1, afterRedir,    0, 0,             1, 1, 0, 0);
      addRow(0, 0,             1, afterRedir,    1, 1, 1, 32'h0040_0200);
      addRow(1, thirdAddr,     0, 0,             1, 1, 0, 0);
      addRow(0, 0,             1, thirdAddr,     1, 1, 0, 0);
      addRow(1, thirdAddr + 32'd4, 0, 0,         0, 0, 0, 0);

      doReset();
      foreach (tbl[i]) begin
         @(negedge clk);
         chk($sformatf("tbl%0d_req", i), {31'd0, ImemReq}, {31'd0, tbl[i].expReq});
         if (tbl[i].expReq) chk($sformatf("tbl%0d_addr", i), ImemAddr, tbl[i].expAddr);
         chk($sformatf("tbl%0d_valid", i), {31'd0, InstrValid}, {31'd0, tbl[i].expValid});
         if (tbl[i].expValid) chkInstr($sformatf("tbl%0d", i), tbl[i].expPc);
         drive(tbl[i].ack, tbl[i].rdy, tbl[i].redir, tbl[i].target);
      end

      // misaligned redirect locks the unit in error until reset
      doReset();
      @(negedge clk);
      chk("err_first_addr", ImemAddr, 32'h0040_0000);
      drive(1, 0, 0, 0);
      @(negedge clk);
      chk("err_valid_pre", {31'd0, InstrValid}, 32'd1);
      drive(1, 1, 1, 32'h0040_0102);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("err_flag", {31'd0, FetchError}, 32'd1);
         chk("err_req", {31'd0, ImemReq}, 32'd0);
         chk("err_valid", {31'd0, InstrValid}, 32'd0);
         drive(1'(i % 2), 1, 1'(i % 3 == 0), 32'h0040_0000);
      end
      doReset();
      @(negedge clk);
      chk("err_clear", {31'd0, FetchError}, 32'd0);
      chk("err_refetch_req", {31'd0, ImemReq}, 32'd1);
      chk("err_refetch_addr", ImemAddr, 32'h0040_0000);

      // reset pulse while waiting for an ack, followed by a stale ack
      drive(1, 0, 0, 0);
      @(negedge clk);
      drive(0, 1, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 0);
      @(negedge clk);
      chk("wait_req", {31'd0, ImemReq}, 32'd1);
      chk("wait_addr", ImemAddr, 32'h0040_0004);
      #2 reset = 1'b0;
      #1;
      chk("rst_req", {31'd0, ImemReq}, 32'd0);
      chk("rst_valid", {31'd0, InstrValid}, 32'd0);
      chk("rst_pcout", PCOut, 32'd0);
      chk("rst_instr", InstrOut, 32'd0);
      chk("rst_err", {31'd0, FetchError}, 32'd0);
      chk("rst_pc", ImemAddr, 32'h0040_0000);
      @(negedge clk);
      chk("rst_hold_req", {31'd0, ImemReq}, 32'd0);
      reset = 1'b1;
      drive(1, 1, 0, 0);
      @(negedge clk);
      chk("stale_valid", {31'd0, InstrValid}, 32'd0);
      chk("stale_req", {31'd0, ImemReq}, 32'd1);
      chk("stale_addr", ImemAddr, 32'h0040_0000);
      drive(0, 1, 0, 0);
      @(negedge clk);
      chk("stale_valid2", {31'd0, InstrValid}, 32'd0);

      // random traffic checked against a transaction-level model
      doReset();
      fetchPc  = 32'h0040_0000;
      expValid = 1'b0;
      inSlot   = 1'b0;
      slotTarget = 32'd0;
      accepts  = 0;
      @(negedge clk);
      for (int cyc = 0; cyc < 600; cyc++) begin
         chk("rnd_req", {31'd0, ImemReq}, {31'd0, !expValid});
         chk("rnd_valid", {31'd0, InstrValid}, {31'd0, expValid});
         if (!expValid) chk("rnd_addr", ImemAddr, fetchPc);
         else           chkInstr("rnd", fetchPc);
         chk("rnd_err", {31'd0, FetchError}, 32'd0);

         ack = ($urandom_range(0, 2) == 0);
         rdy = ($urandom_range(0, 1) == 0);
         rd  = ($urandom_range(0, 3) == 0);
         tgt = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         drive(ack, rdy, rd, tgt);

         if (!expValid) begin
            if (ack) expValid = 1'b1;
         end else if (rdy) begin
            expValid = 1'b0;
            accepts++;
            if (DS && inSlot) begin
               fetchPc = slotTarget;
               inSlot  = 1'b0;
            end else if (rd) begin
               if (DS) begin
                  slotTarget = tgt;
                  inSlot     = 1'b1;
                  fetchPc    = fetchPc + 32'd4;
               end else begin
                  fetchPc = tgt;
               end
            end else begin
               fetchPc = fetchPc + 32'd4;
            end
         end
         @(negedge clk);
      end
      total++;
      if (accepts < 20) begin
         bad++;
         $display("FAIL rnd_accepts: got %0d expected at least 20", accepts);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
